// File: rtl/sdram_pkg.sv
// Shared SDRAM encodings: command pin patterns, arbiter states and idle bus values.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_P_CHARGE  = 4'b0010;
  localparam logic [3:0] CMD_A_REF     = 4'b0001;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_M_REG_SET = 4'b0000;

  localparam logic [1:0] IDLE_BA = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdram_arbit_if.sv
// Request/grant handshake and SDRAM pin bundle between the sub-controllers, the arbiter and the pads.
interface sdram_arbit_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              init_end;
  logic [3:0]        init_cmd;
  logic [1:0]        init_ba;
  logic [ADDR_W-1:0] init_addr;
  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [1:0]        aref_ba;
  logic [ADDR_W-1:0] aref_addr;
  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_sdram_en;
  logic [DATA_W-1:0] wr_sdram_data;
  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_ba;
  logic [ADDR_W-1:0] rd_addr;
  logic              aref_en;
  logic              wr_en;
  logic              rd_en;
  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [1:0]        sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;

  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
  );

  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_sdram_data,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command-bus owner: waits for init, then grants refresh/write/read one at a time
// and muxes the granted source onto the pins until that source signals its end.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W        = 13,
  parameter int DATA_W        = 16,
  parameter int MAX_WR_STREAK = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  sdram_arbit_if.slave  bus
);

  localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

  arb_state_e          state_r, next_state_s;
  logic                aref_en_r, wr_en_r, rd_en_r;
  logic                next_aref_en_s, next_wr_en_s, next_rd_en_s;
  logic [STREAK_W-1:0] streak_r, next_streak_s;
  logic                read_forced_s;
  logic [3:0]          cmd_s;
  logic [1:0]          ba_s;
  logic [ADDR_W-1:0]   addr_s;

  // A pending read gets the bus once writes have won MAX_WR_STREAK times in a row.
  assign read_forced_s = bus.rd_req && (streak_r == STREAK_MAX);

  // State, grant and streak registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r   <= ST_INIT;
      aref_en_r <= 1'b0;
      wr_en_r   <= 1'b0;
      rd_en_r   <= 1'b0;
      streak_r  <= '0;
    end else begin
      state_r   <= next_state_s;
      aref_en_r <= next_aref_en_s;
      wr_en_r   <= next_wr_en_s;
      rd_en_r   <= next_rd_en_s;
      streak_r  <= next_streak_s;
    end
  end

  // Next-state, grant and streak decision.
  always_comb begin
    next_state_s   = state_r;
    next_aref_en_s = aref_en_r;
    next_wr_en_s   = wr_en_r;
    next_rd_en_s   = rd_en_r;
    next_streak_s  = streak_r;
    case (state_r)
      ST_INIT: begin
        if (bus.init_end) begin
          next_state_s = ST_ARBIT;
        end else begin
          next_state_s = ST_INIT;
        end
      end
      ST_ARBIT: begin
        if (bus.aref_req) begin
          next_state_s   = ST_AREF;
          next_aref_en_s = 1'b1;
        end else if (bus.wr_req && !read_forced_s) begin
          next_state_s = ST_WRITE;
          next_wr_en_s = 1'b1;
          if (!bus.rd_req) begin
            next_streak_s = '0;
          end else if (streak_r < STREAK_MAX) begin
            next_streak_s = streak_r + {{(STREAK_W-1){1'b0}}, 1'b1};
          end else begin
            next_streak_s = STREAK_MAX;
          end
        end else if (bus.rd_req) begin
          next_state_s  = ST_READ;
          next_rd_en_s  = 1'b1;
          next_streak_s = '0;
        end else begin
          next_state_s = ST_ARBIT;
        end
      end
      ST_AREF: begin
        if (bus.aref_end) begin
          next_state_s   = ST_ARBIT;
          next_aref_en_s = 1'b0;
        end else begin
          next_state_s = ST_AREF;
        end
      end
      ST_WRITE: begin
        if (bus.wr_end) begin
          next_state_s = ST_ARBIT;
          next_wr_en_s = 1'b0;
        end else begin
          next_state_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (bus.rd_end) begin
          next_state_s = ST_ARBIT;
          next_rd_en_s = 1'b0;
        end else begin
          next_state_s = ST_READ;
        end
      end
      default: begin
        next_state_s   = ST_INIT;
        next_aref_en_s = 1'b0;
        next_wr_en_s   = 1'b0;
        next_rd_en_s   = 1'b0;
      end
    endcase
  end

  // Zero-latency pin mux keyed on the current owner of the bus.
  always_comb begin
    cmd_s  = CMD_NOP;
    ba_s   = IDLE_BA;
    addr_s = {ADDR_W{1'b1}};
    case (state_r)
      ST_INIT: begin
        cmd_s  = bus.init_cmd;
        ba_s   = bus.init_ba;
        addr_s = bus.init_addr;
      end
      ST_AREF: begin
        cmd_s  = bus.aref_cmd;
        ba_s   = bus.aref_ba;
        addr_s = bus.aref_addr;
      end
      ST_WRITE: begin
        cmd_s  = bus.wr_cmd;
        ba_s   = bus.wr_ba;
        addr_s = bus.wr_addr;
      end
      ST_READ: begin
        cmd_s  = bus.rd_cmd;
        ba_s   = bus.rd_ba;
        addr_s = bus.rd_addr;
      end
      default: begin
        cmd_s  = CMD_NOP;
        ba_s   = IDLE_BA;
        addr_s = {ADDR_W{1'b1}};
      end
    endcase
  end

  assign bus.aref_en      = aref_en_r;
  assign bus.wr_en        = wr_en_r;
  assign bus.rd_en        = rd_en_r;
  assign bus.sdram_cke    = 1'b1;
  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd_s;
  assign bus.sdram_ba     = ba_s;
  assign bus.sdram_addr   = addr_s;
  assign bus.sdram_dq_out = bus.wr_sdram_data[DATA_W-1:0];
  assign bus.sdram_dq_oe  = bus.wr_sdram_en && (state_r == ST_WRITE);

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: a bus-owner model checked every cycle, plus literal spot checks.
module tb_sdram_arbit;

  localparam int MAXS = 4;

  logic sys_clk;
  logic sys_rst_n;
  sdram_arbit_if #(.ADDR_W(13), .DATA_W(16)) bus ();

  sdram_arbit #(.ADDR_W(13), .DATA_W(16), .MAX_WR_STREAK(MAXS)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: who owns the bus ("N" none, "A"/"W"/"R"), whether init is done, and the write run length.
  bit  m_init = 1'b0;
  byte m_gnt  = "N";
  int  m_wrs  = 0;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_init <= 1'b0;
      m_gnt  <= "N";
      m_wrs  <= 0;
    end else if (!m_init) begin
      m_init <= bus.init_end;
    end else if (m_gnt == "N") begin
      if (bus.aref_req) m_gnt <= "A";
      else if (bus.wr_req && !(bus.rd_req && m_wrs == MAXS)) begin
        m_gnt <= "W";
        m_wrs <= bus.rd_req ? ((m_wrs < MAXS) ? m_wrs + 1 : MAXS) : 0;
      end else if (bus.rd_req) begin
        m_gnt <= "R";
        m_wrs <= 0;
      end
    end else if ((m_gnt == "A" && bus.aref_end) || (m_gnt == "W" && bus.wr_end) ||
                 (m_gnt == "R" && bus.rd_end)) begin
      m_gnt <= "N";
    end
  end

  function automatic logic [39:0] exp_vec();
    logic [3:0]  c;
    logic [1:0]  b;
    logic [12:0] a;
    if (!m_init) begin
      c = bus.init_cmd; b = bus.init_ba; a = bus.init_addr;
    end else if (m_gnt == "A") begin
      c = bus.aref_cmd; b = bus.aref_ba; a = bus.aref_addr;
    end else if (m_gnt == "W") begin
      c = bus.wr_cmd; b = bus.wr_ba; a = bus.wr_addr;
    end else if (m_gnt == "R") begin
      c = bus.rd_cmd; b = bus.rd_ba; a = bus.rd_addr;
    end else begin
      c = 4'b0111; b = 2'b11; a = 13'h1FFF;
    end
    return {m_gnt == "A", m_gnt == "W", m_gnt == "R", 1'b1, c, b, a,
            (m_gnt == "W") && bus.wr_sdram_en, bus.wr_sdram_data};
  endfunction

  function automatic logic [39:0] dut_vec();
    return {bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_cke,
            bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
            bus.sdram_ba, bus.sdram_addr, bus.sdram_dq_oe, bus.sdram_dq_out};
  endfunction

  function automatic logic [18:0] pins();
    return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n,
            bus.sdram_ba, bus.sdram_addr};
  endfunction

  // Per-cycle comparison against the model, half a period after each active edge.
  always @(negedge sys_clk) begin
    if (chk_en) chk("cycle", {24'd0, dut_vec()}, {24'd0, exp_vec()});
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  logic [47:0] order;
  byte         g;
  bit          got;

  initial begin
    sys_rst_n = 1'b0;
    bus.init_end = 1'b0;
    bus.init_cmd = 4'b0010; bus.init_ba = 2'b01; bus.init_addr = 13'h0400;
    bus.aref_req = 1'b0; bus.aref_end = 1'b0;
    bus.aref_cmd = 4'b0001; bus.aref_ba = 2'b10; bus.aref_addr = 13'h1AAA;
    bus.wr_req = 1'b1; bus.wr_end = 1'b0;
    bus.wr_cmd = 4'b0100; bus.wr_ba = 2'b00; bus.wr_addr = 13'h0123;
    bus.wr_sdram_en = 1'b0; bus.wr_sdram_data = 16'h0000;
    bus.rd_req = 1'b0; bus.rd_end = 1'b0;
    bus.rd_cmd = 4'b0101; bus.rd_ba = 2'b01; bus.rd_addr = 13'h0456;
    order = 48'd0;
    chk_en = 1'b1;

    step(1);
    chk("reset_en", {61'd0, bus.aref_en, bus.wr_en, bus.rd_en}, 64'd0);
    chk("reset_cke", {63'd0, bus.sdram_cke}, 64'd1);
    step(2);
    sys_rst_n = 1'b1;

    // Held in INIT despite a write request.
    step(20);
    chk("init_hold_wr_en", {63'd0, bus.wr_en}, 64'd0);
    chk("init_hold_pins", {45'd0, pins()}, {45'd0, 4'b0010, 2'b01, 13'h0400});
    bus.init_end = 1'b1;
    step(1);
    chk("init_arbit_nop", {44'd0, bus.wr_en, pins()}, {44'd0, 1'b0, 4'b0111, 2'b11, 13'h1FFF});
    step(1);
    chk("first_write_grant", {60'd0, bus.wr_en, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n},
        {60'd0, 1'b1, 3'b010});
    bus.wr_req = 1'b0; bus.wr_end = 1'b1;
    step(1);
    bus.wr_end = 1'b0;
    chk("first_write_release", {63'd0, bus.wr_en}, 64'd0);

    // Writes and reads both pending: write streak then a forced read.
    bus.wr_sdram_en = 1'b1; bus.wr_sdram_data = 16'hA5A5;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      g = "N";
      for (int t = 0; t < 6 && !got; t++) begin
        step(1);
        if (bus.wr_en) begin got = 1'b1; g = "W"; end
        else if (bus.rd_en) begin got = 1'b1; g = "R"; end
        else if (bus.aref_en) begin got = 1'b1; g = "A"; end
        else got = 1'b0;
      end
      if (!got) begin
        chk("grant_wait_timeout", 64'd0, 64'd1);
        break;
      end
      order = {order[39:0], g};
      if (k == 0) chk("dq_write", {47'd0, bus.sdram_dq_oe, bus.sdram_dq_out}, {47'd0, 1'b1, 16'hA5A5});
      if (g == "R") chk("dq_read_gated", {63'd0, bus.sdram_dq_oe}, 64'd0);
      step(9);
      if (k == 5) begin bus.wr_req = 1'b0; bus.rd_req = 1'b0; end
      if (g == "W") bus.wr_end = 1'b1;
      else if (g == "R") bus.rd_end = 1'b1;
      else bus.aref_end = 1'b1;
      step(1);
      bus.wr_end = 1'b0; bus.rd_end = 1'b0; bus.aref_end = 1'b0;
    end
    chk("grant_order", {16'd0, order}, {16'd0, "WWWWRW"});
    bus.wr_sdram_en = 1'b0;

    // All three requesting: refresh first, stray rd_end ignored, then write.
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    step(1);
    chk("aref_first", {44'd0, bus.aref_en, pins()}, {44'd0, 1'b1, 4'b0001, 2'b10, 13'h1AAA});
    bus.rd_end = 1'b1;
    step(1);
    bus.rd_end = 1'b0;
    step(1);
    chk("stray_rd_end", {61'd0, bus.aref_en, bus.wr_en, bus.rd_en}, 64'd4);
    bus.aref_req = 1'b0; bus.aref_end = 1'b1;
    step(1);
    bus.aref_end = 1'b0;
    chk("aref_release_nop", {44'd0, bus.aref_en, pins()}, {44'd0, 1'b0, 4'b0111, 2'b11, 13'h1FFF});
    step(1);
    chk("write_after_aref", {61'd0, bus.aref_en, bus.wr_en, bus.rd_en}, 64'd2);

    // Refresh request during a write does not preempt it.
    bus.aref_req = 1'b1;
    step(3);
    chk("no_preempt", {61'd0, bus.aref_en, bus.wr_en, bus.rd_en}, 64'd2);
    bus.wr_end = 1'b1;
    step(1);
    bus.wr_end = 1'b0;
    chk("write_release", {63'd0, bus.wr_en}, 64'd0);
    step(1);
    chk("aref_after_write", {61'd0, bus.aref_en, bus.wr_en, bus.rd_en}, 64'd4);

    // Read grant, then asynchronous reset in the middle of it.
    bus.wr_req = 1'b0; bus.aref_req = 1'b0; bus.aref_end = 1'b1;
    step(1);
    bus.aref_end = 1'b0;
    step(1);
    chk("read_grant", {44'd0, bus.rd_en, pins()}, {44'd0, 1'b1, 4'b0101, 2'b01, 13'h0456});
    step(3);
    sys_rst_n = 1'b0;
    #1;
    chk("async_reset_rd_en", {44'd0, bus.rd_en, pins()}, {44'd0, 1'b0, 4'b0010, 2'b01, 13'h0400});
    bus.init_end = 1'b0;
    step(2);
    sys_rst_n = 1'b1;
    step(5);
    chk("reinit_hold", {63'd0, bus.rd_en}, 64'd0);
    bus.init_end = 1'b1;
    step(1);
    chk("reinit_arbit_nop", {60'd0, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n},
        {60'd0, 4'b0111});
    step(1);
    chk("reinit_read", {63'd0, bus.rd_en}, 64'd1);
    bus.rd_req = 1'b0; bus.rd_end = 1'b1;
    step(1);
    bus.rd_end = 1'b0;
    step(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
